// File: rtl/add3_pkg.sv
// Shared types and constants for the add3 operand sequencer.
// The LFSR tap table and total_beats() serve the optional LFSR build (SEQ_LFSR_EN).
package add3_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } seq_state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned MAX_LFSR_BITS = 24;

  // Maximal-length Fibonacci tap masks for a 3*width-bit register.
  // Bit i set means register bit i feeds the XOR. A result of zero means no entry exists.
  function automatic logic [MAX_LFSR_BITS-1:0] lfsr_taps(input int unsigned width);
    case (width)
      1:       lfsr_taps = 24'h000006; // 3:  taps 3,2
      2:       lfsr_taps = 24'h000030; // 6:  taps 6,5
      3:       lfsr_taps = 24'h000110; // 9:  taps 9,5
      4:       lfsr_taps = 24'h000829; // 12: taps 12,6,4,1
      5:       lfsr_taps = 24'h006000; // 15: taps 15,14
      6:       lfsr_taps = 24'h020400; // 18: taps 18,11
      7:       lfsr_taps = 24'h140000; // 21: taps 21,19
      8:       lfsr_taps = 24'he10000; // 24: taps 24,23,22,17
      default: lfsr_taps = '0;
    endcase
  endfunction

  // Number of beats in one complete sweep. The LFSR never emits the all-zero triple.
  function automatic longint unsigned total_beats(input int unsigned width, input logic lfsr);
    longint unsigned full;
    full = 64'd1 << (3 * width);
    total_beats = lfsr ? (full - 64'd1) : full;
  endfunction

endpackage

// File: rtl/add3_lfsr.sv
// Generic N-bit Fibonacci LFSR with synchronous seed load and step enable.
// The taps are supplied as a mask, and the register shifts toward the MSB.
module add3_lfsr #(
  parameter int unsigned N = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [N-1:0] seed,
  input  logic [N-1:0] taps,
  output logic [N-1:0] state
);

  logic [N-1:0] state_q, state_d;

  // A load takes priority over a step, and the feedback enters at bit 0.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = seed;
    end else if (en) begin
      state_d = {state_q[N-2:0], ^(state_q & taps)};
    end
  end

  // State register. It resets to a nonzero value so that the register can never lock up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= N'(1);
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/add3_operand_seq.sv
// Operand-triple sequencer for the add3 adder.
// The default build sweeps every (a,b,c) combination. a changes fastest, then b, then c.
// The optional macro SEQ_LFSR_EN adds lfsr_mode. With that port set, {c,b,a} comes from a maximal LFSR.
// All outputs are driven by registers, so no input reaches an output combinationally.
module add3_operand_seq
  import add3_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               out_ready,
`ifdef SEQ_LFSR_EN
  input  logic               lfsr_mode,
`endif
  output logic               out_valid,
  output logic [WIDTH-1:0]   a,
  output logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   c,
  output logic               busy,
  output logic               done,
  output logic [3*WIDTH:0]   beat_cnt
);

  localparam int unsigned N  = 3 * WIDTH;
  localparam int unsigned CW = N + 1;
  localparam logic [CW-1:0] LAST_EXH = CW'(total_beats(WIDTH, 1'b0) - 64'd1);

  seq_state_t        state_q, state_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mode_q, mode_d;
  logic              start_go, step_go;
  logic              lfsr_sel;
  logic              last_beat;

`ifdef SEQ_LFSR_EN
  localparam logic [MAX_LFSR_BITS-1:0] TAPS_ALL = lfsr_taps(WIDTH);
  localparam logic [N-1:0] TAPS = TAPS_ALL[N-1:0];
  localparam logic [CW-1:0] LAST_LFSR = CW'(total_beats(WIDTH, 1'b1) - 64'd1);

  if (TAPS_ALL == '0) begin : g_no_taps
    $error("add3_operand_seq: no LFSR tap entry for WIDTH=%0d", WIDTH);
  end

  logic [N-1:0] lfsr_state;

  add3_lfsr #(.N(N)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (start_go),
    .en    (step_go && mode_q),
    .seed  (N'(1)),
    .taps  (TAPS),
    .state (lfsr_state)
  );

  assign lfsr_sel  = lfsr_mode;
  assign last_beat = (cnt_q == (mode_q ? LAST_LFSR : LAST_EXH));
  // The mode flop picks which register set drives the operands. Reset clears it, so a/b/c read zero.
  assign {c, b, a} = mode_q ? lfsr_state : {c_q, b_q, a_q};
`else
  assign lfsr_sel  = 1'b0;
  assign last_beat = (cnt_q == LAST_EXH);
  assign {c, b, a} = {c_q, b_q, a_q};
`endif

  // Next state. Abort beats start and beats a same-cycle accept, which is then not counted.
  always_comb begin
    state_d           = state_q;
    valid_d           = valid_q;
    {c_d, b_d, a_d}   = {c_q, b_q, a_q};
    cnt_d             = cnt_q;
    mode_d            = mode_q;
    start_go          = 1'b0;
    step_go           = 1'b0;
    if (abort) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            start_go        = 1'b1;
            state_d         = RUN;
            valid_d         = 1'b1;
            {c_d, b_d, a_d} = '0;
            cnt_d           = '0;
            mode_d          = lfsr_sel;
          end
        end
        RUN: begin
          if (valid_q && out_ready) begin
            cnt_d = cnt_q + CW'(1);
            if (last_beat) begin
              state_d = DONE;
              valid_d = 1'b0;
            end else begin
              step_go = 1'b1;
              // A single N-bit increment is the a->b->c carry chain.
              if (!mode_q) begin
                {c_d, b_d, a_d} = {c_q, b_q, a_q} + N'(1);
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  assign out_valid = valid_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign beat_cnt  = cnt_q;

endmodule
